// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout input path: button indices, default
// timing constants and the auto-repeat state encoding.
package breakout_pkg;

  localparam int unsigned BTN_LEFT   = 0;
  localparam int unsigned BTN_RIGHT  = 1;
  localparam int unsigned BTN_SELECT = 2;

  localparam int unsigned N_BTN_DEF           = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250_000;    // ~10 ms at 25.175 MHz
  localparam int unsigned REPEAT_DELAY_DEF    = 10_000_000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 2_500_000;
  localparam logic [2:0]  REPEAT_EN_DEF       = 3'b011;     // paddle buttons only

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce filter, registered edge strobes
// and auto-repeat FSM.
//
// state      | meaning
// -----------|------------------------------------------------------------
// RPT_IDLE   | released, or held with repeat disabled; waiting for a press
// RPT_DELAY  | held; counting REPEAT_DELAY cycles to the first repeat
// RPT_REPEAT | held; pulsing every REPEAT_PERIOD cycles
module button_channel
  import breakout_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_TC = RPT_W'(REPEAT_PERIOD - 1);

  logic            sync1, sync2, stable;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Edges are taken against the registered level so strobes line up with it.
  logic rise, fall;
  assign rise = stable & ~btn_level;
  assign fall = ~stable & btn_level;

  rpt_state_t       rpt_state, rpt_next;
  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_next;
  logic             rep_pulse;

  always_comb begin
    rpt_next     = rpt_state;
    rpt_cnt_next = rpt_cnt;
    rep_pulse    = 1'b0;
    unique case (rpt_state)
      RPT_IDLE: begin
        if (rise) begin
          rep_pulse    = 1'b1;
          rpt_cnt_next = '0;
          if (REPEAT_EN) rpt_next = RPT_DELAY;
        end
      end
      RPT_DELAY: begin
        if (!stable) begin
          rpt_next = RPT_IDLE;
        end else if (rpt_cnt == DLY_TC) begin
          rep_pulse    = 1'b1;
          rpt_cnt_next = '0;
          rpt_next     = RPT_REPEAT;
        end else begin
          rpt_cnt_next = rpt_cnt + RPT_W'(1);
        end
      end
      RPT_REPEAT: begin
        if (!stable) begin
          rpt_next = RPT_IDLE;
        end else if (rpt_cnt == PER_TC) begin
          rep_pulse    = 1'b1;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt + RPT_W'(1);
        end
      end
      default: rpt_next = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_state   <= RPT_IDLE;
      rpt_cnt     <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      rpt_state   <= rpt_next;
      rpt_cnt     <= rpt_cnt_next;
      btn_level   <= stable;
      btn_press   <= rise;
      btn_release <= fall;
      btn_repeat  <= rep_pulse;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw button pins for the game core: one independent
// button_channel per button.
module button_conditioner
  import breakout_pkg::*;
#(
  parameter int unsigned           N_BTN           = N_BTN_DEF,
  parameter int unsigned           DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned           REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned           REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter logic [N_BTN-1:0]      REPEAT_EN       = N_BTN'(REPEAT_EN_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN[i])
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level, btn_press, btn_release, btn_repeat;

  int n_vec = 0;
  int n_err = 0;

  button_conditioner #(
    .N_BTN           (3),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3),
    .REPEAT_EN       (3'b011)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return {20'd0, btn_level, btn_press, btn_release, btn_repeat};
  endfunction

  initial begin
    rst     = 1'b1;
    btn_raw = 3'($urandom);

    // reset with random pins
    for (int i = 0; i < 5; i++) begin
      tick(1);
      btn_raw = 3'($urandom);
      check($sformatf("rst_hold_%0d", i), all_out(), 32'd0);
    end
    rst     = 1'b0;
    btn_raw = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("post_rst_%0d", i), all_out(), 32'd0);
    end

    // clean press on channel 0: first sampled at edge k
    btn_raw[0] = 1'b1;
    tick(6);                                  // after k+5
    check("press_early_level", {31'd0, btn_level[0]}, 32'd0);
    check("press_early_strobe", {31'd0, btn_press[0]}, 32'd0);
    tick(1);                                  // after k+6
    check("press_level", {31'd0, btn_level[0]}, 32'd1);
    check("press_strobe", {31'd0, btn_press[0]}, 32'd1);
    check("press_repeat", {31'd0, btn_repeat[0]}, 32'd1);
    tick(1);                                  // after k+7
    check("press_one_wide", {31'd0, btn_press[0]}, 32'd0);
    check("press_level_hold", {31'd0, btn_level[0]}, 32'd1);

    // clean release
    btn_raw[0] = 1'b0;
    tick(6);
    check("rel_early", {31'd0, btn_release[0]}, 32'd0);
    tick(1);
    check("rel_strobe", {31'd0, btn_release[0]}, 32'd1);
    check("rel_level", {31'd0, btn_level[0]}, 32'd0);
    check("rel_no_repeat", {31'd0, btn_repeat[0]}, 32'd0);
    tick(1);
    check("rel_one_wide", {31'd0, btn_release[0]}, 32'd0);
    tick(4);

    // 3-cycle glitch: filtered out
    btn_raw[0] = 1'b1;
    tick(3);
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("glitch_%0d", i), all_out(), 32'd0);
    end

    // bounce: high 2, low 1, then held; last rise sampled at edge e
    btn_raw[0] = 1'b1;
    tick(2);
    btn_raw[0] = 1'b0;
    tick(1);
    btn_raw[0] = 1'b1;
    for (int i = 0; i <= 5; i++) begin        // after e .. e+5
      tick(1);
      check($sformatf("bounce_quiet_%0d", i), all_out(), 32'd0);
    end
    tick(1);                                  // after e+6
    check("bounce_level", {29'd0, btn_level}, 32'd1);
    check("bounce_press", {29'd0, btn_press}, 32'd1);
    tick(1);
    check("bounce_press_once", {29'd0, btn_press}, 32'd0);
    btn_raw[0] = 1'b0;
    tick(12);
    check("bounce_released", {29'd0, btn_level}, 32'd0);

    // auto-repeat on channel 1; release lands on the P+17 repeat slot
    btn_raw[1] = 1'b1;
    tick(7);                                  // cycle P
    check("rpt1_press", {31'd0, btn_press[1]}, 32'd1);
    check("rpt1_p0", {31'd0, btn_repeat[1]}, 32'd1);
    for (int j = 1; j <= 22; j++) begin
      tick(1);
      check($sformatf("rpt1_rep_P+%0d", j), {31'd0, btn_repeat[1]},
            (j == 8 || j == 11 || j == 14) ? 32'd1 : 32'd0);
      check($sformatf("rpt1_rel_P+%0d", j), {31'd0, btn_release[1]},
            (j == 17) ? 32'd1 : 32'd0);
      if (j == 10) btn_raw[1] = 1'b0;
    end

    // channel 2 has repeat disabled
    btn_raw[2] = 1'b1;
    tick(7);
    check("rpt2_press", {31'd0, btn_press[2]}, 32'd1);
    check("rpt2_p0", {31'd0, btn_repeat[2]}, 32'd1);
    for (int j = 1; j <= 15; j++) begin
      tick(1);
      check($sformatf("rpt2_none_P+%0d", j), {31'd0, btn_repeat[2]}, 32'd0);
    end
    btn_raw[2] = 1'b0;
    tick(10);
    check("rpt2_released", {29'd0, btn_level}, 32'd0);

    // simultaneous press, then release channel 0 only
    btn_raw = 3'b111;
    tick(7);
    check("sim_press", {29'd0, btn_press}, 32'h7);
    check("sim_repeat", {29'd0, btn_repeat}, 32'h7);
    tick(1);
    check("sim_press_clear", {29'd0, btn_press}, 32'd0);
    btn_raw = 3'b110;
    tick(7);
    check("sim_release", {29'd0, btn_release}, 32'h1);
    check("sim_level", {29'd0, btn_level}, 32'h6);

    // async reset mid-repeat, buttons still held
    tick(6);
    check("midhold_level", {29'd0, btn_level}, 32'h6);
    #2;
    rst = 1'b1;
    #1;
    check("midhold_async_zero", all_out(), 32'd0);
    tick(2);
    check("midhold_in_rst", all_out(), 32'd0);
    rst = 1'b0;                               // next edge is k
    tick(6);                                  // after k+5
    check("midhold_no_press_yet", {29'd0, btn_press}, 32'd0);
    tick(1);                                  // after k+6
    check("midhold_repress", {29'd0, btn_press}, 32'h6);
    check("midhold_repeat", {29'd0, btn_repeat}, 32'h6);
    tick(1);
    check("midhold_press_once", {29'd0, btn_press}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
